// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simon_pkg
// Description : Shared constants, rotate helpers and FSM state type for the
//               SIMON 64/128 encryptor.
// Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    localparam int SIMON_N = 32;
    localparam int SIMON_T = 44;
    localparam int RND_W   = 6;

    // Literal is written with z3[0] leftmost; SIMON_Z3 holds it reversed so bit i = z3[i]
    localparam logic [61:0] SIMON_Z3_LIT =
        62'b11011011101011000110010111100000010010001010011100110100001111;

    function automatic logic [61:0] rev62(input logic [61:0] v);
        logic [61:0] r;
        for (int i = 0; i < 62; i++) begin
            r[i] = v[61-i];
        end
        return r;
    endfunction

    localparam logic [61:0] SIMON_Z3 = rev62(SIMON_Z3_LIT);

    function automatic logic [SIMON_N-1:0] rotl(input logic [SIMON_N-1:0] x, input int unsigned s);
        return (x << s) | (x >> (SIMON_N - s));
    endfunction

    function automatic logic [SIMON_N-1:0] rotr(input logic [SIMON_N-1:0] x, input int unsigned s);
        return (x >> s) | (x << (SIMON_N - s));
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } simon_state_e;

endpackage
`default_nettype wire

// File: rtl/simon_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : simon_key_expand
// Description : Combinational SIMON 64/128 key-schedule step (m = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module simon_key_expand
    import simon_pkg::*;
(
    input  logic [SIMON_N-1:0] k0,
    input  logic [SIMON_N-1:0] k1,
    input  logic [SIMON_N-1:0] k3,
    input  logic [RND_W-1:0]   rnd,
    output logic [SIMON_N-1:0] knew
);

    logic [SIMON_N-1:0] t0;
    logic [SIMON_N-1:0] t1;

    always_comb begin
        t0   = rotr(k3, 3) ^ k1;
        t1   = t0 ^ rotr(t0, 1);
        knew = ~k0 ^ t1 ^ {{(SIMON_N-1){1'b0}}, SIMON_Z3[rnd]} ^ 32'h3;
    end

endmodule
`default_nettype wire

// File: rtl/simon_encrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : simon_encrypt_iter
// Description : Iterative SIMON 64/128 encryptor, one round per clock with an
//               on-the-fly key schedule and valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_encrypt_iter
    import simon_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int ROUNDS = 44
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   input_Val,
    input  logic [127:0]       keySeed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   encrypted_Val
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    simon_state_e       state_q, state_d;
    logic [SIMON_N-1:0] x_q, x_d, y_q, y_d;
    logic [SIMON_N-1:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [SIMON_N-1:0] knew;
    logic [SIMON_N-1:0] f_x;

    simon_key_expand u_key_expand (
        .k0   (k0_q),
        .k1   (k1_q),
        .k3   (k3_q),
        .rnd  (rnd_q),
        .knew (knew)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)        state_d = RUN;
            RUN:     if (rnd_q == LAST_RND) state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        f_x   = (rotl(x_q, 1) & rotl(x_q, 8)) ^ rotl(x_q, 2);
        x_d   = x_q;
        y_d   = y_q;
        k0_d  = k0_q;
        k1_d  = k1_q;
        k2_d  = k2_q;
        k3_d  = k3_q;
        rnd_d = rnd_q;
        if (state_q == IDLE && in_valid) begin
            x_d   = input_Val[WIDTH-1:WIDTH/2];
            y_d   = input_Val[WIDTH/2-1:0];
            k0_d  = keySeed[31:0];
            k1_d  = keySeed[63:32];
            k2_d  = keySeed[95:64];
            k3_d  = keySeed[127:96];
            rnd_d = '0;
        end else if (state_q == RUN) begin
            // Round key for this round is k0; the window then slides by one word
            x_d   = y_q ^ f_x ^ k0_q;
            y_d   = x_q;
            k0_d  = k1_q;
            k1_d  = k2_q;
            k2_d  = k3_q;
            k3_d  = knew;
            rnd_d = rnd_q + RND_W'(1);
        end
    end

    always_comb begin
        in_ready      = (state_q == IDLE);
        out_valid     = (state_q == DONE);
        encrypted_Val = out_valid ? {x_q, y_q} : '0;
    end

endmodule
`default_nettype wire
